// File: rtl/alu_pkg.sv
// Shared constants for the add/subtract result path.
// Entry layout: {N, Z, OF, SEL, Y} packed into ALU_W + 4 bits.
package alu_pkg;

  localparam int ALU_W = 6;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int ENT_Y   = 0;
  localparam int ENT_SEL = ALU_W;
  localparam int ENT_OF  = ALU_W + 1;
  localparam int ENT_Z   = ALU_W + 2;
  localparam int ENT_N   = ALU_W + 3;
  localparam int ENT_W   = ALU_W + 4;

endpackage

// File: rtl/alu_result_capture_6b_if.sv
// Handshake and status bundle of the ALU result capture stage.
// slave = capture stage, master = producer/consumer side.
interface alu_result_capture_6b_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
);
  logic                     IN_VALID;
  logic                     IN_READY;
  logic                     SEL;
  logic [WIDTH-1:0]         Y;
  logic                     OF_SUM_REST;
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic [WIDTH-1:0]         R;
  logic                     R_SEL;
  logic                     FLAG_Z;
  logic                     FLAG_N;
  logic                     FLAG_OF;
  logic                     STICKY_OF;
  logic                     CLR_OF;
  logic [CNT_W-1:0]         OF_CNT;
  logic [$clog2(DEPTH):0]   COUNT;

  modport slave (
    input  IN_VALID, SEL, Y, OF_SUM_REST,
    input  OUT_READY, CLR_OF,
    output IN_READY, OUT_VALID, R, R_SEL,
    output FLAG_Z, FLAG_N, FLAG_OF,
    output STICKY_OF, OF_CNT, COUNT
  );

  modport master (
    output IN_VALID, SEL, Y, OF_SUM_REST,
    output OUT_READY, CLR_OF,
    input  IN_READY, OUT_VALID, R, R_SEL,
    input  FLAG_Z, FLAG_N, FLAG_OF,
    input  STICKY_OF, OF_CNT, COUNT
  );
endinterface

// File: rtl/alu_res_fifo.sv
// Generic show-ahead FIFO: dout always presents the entry at the
// read pointer; occupancy is tracked in an explicit counter.
module alu_res_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [AW:0]   C_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_result_capture_6b.sv
// Captures add/subtract results with derived flags into a show-ahead
// FIFO; keeps a sticky overflow flag and a saturating overflow count.
module alu_result_capture_6b
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input logic CLK,
  input logic RST,
  alu_result_capture_6b_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [ENT_W-1:0] din;
  logic [ENT_W-1:0] dout;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             of_push;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  assign bus.IN_READY  = ~full & ~RST;
  assign bus.OUT_VALID = ~empty;
  assign push    = bus.IN_VALID & bus.IN_READY;
  assign pop     = bus.OUT_VALID & bus.OUT_READY;
  assign of_push = push & bus.OF_SUM_REST;

  always_comb begin
    din = '0;
    din[ENT_Y +: ALU_W] = bus.Y;
    din[ENT_SEL]        = bus.SEL;
    din[ENT_OF]         = bus.OF_SUM_REST;
    din[ENT_Z]          = (bus.Y == '0);
    din[ENT_N]          = bus.Y[WIDTH-1];
  end

  alu_res_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // stale memory must never leak out while the queue is empty
  always_comb begin
    bus.R       = '0;
    bus.R_SEL   = 1'b0;
    bus.FLAG_Z  = 1'b0;
    bus.FLAG_N  = 1'b0;
    bus.FLAG_OF = 1'b0;
    if (!empty) begin
      bus.R       = dout[ENT_Y +: ALU_W];
      bus.R_SEL   = dout[ENT_SEL];
      bus.FLAG_Z  = dout[ENT_Z];
      bus.FLAG_N  = dout[ENT_N];
      bus.FLAG_OF = dout[ENT_OF];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (of_push)         sticky_q <= 1'b1;
      else if (bus.CLR_OF) sticky_q <= 1'b0;
      if (bus.CLR_OF)
        cnt_q <= of_push ? CNT_ONE : '0;
      else if (of_push && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign bus.STICKY_OF = sticky_q;
  assign bus.OF_CNT    = cnt_q;
  assign bus.COUNT     = count;
endmodule

// File: tb/tb_alu_result_capture_6b.sv
// Directed bench for alu_result_capture_6b.
// Each task drives one scenario and checks inline.
module tb_alu_result_capture_6b;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_result_capture_6b_if #(.WIDTH(6), .DEPTH(4), .CNT_W(4)) bus ();

  alu_result_capture_6b #(.WIDTH(6), .DEPTH(4), .CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.SEL = 1'b0;
    bus.Y = '0;
    bus.OF_SUM_REST = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.CLR_OF = 1'b0;
    step();
    step();
    checks++;
    if (bus.COUNT !== 3'd0) begin
      errors++; $display("FAIL rst_count: got %0d want 0", bus.COUNT);
    end
    checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.R !== 6'd0) begin
      errors++; $display("FAIL rst_out: valid=%b r=%0d want 0", bus.OUT_VALID, bus.R);
    end
    checks++;
    if (bus.IN_READY !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready: got %b want 0", bus.IN_READY);
    end
    checks++;
    if (bus.STICKY_OF !== 1'b0 || bus.OF_CNT !== 4'd0) begin
      errors++; $display("FAIL rst_of: sticky=%b cnt=%0d want 0", bus.STICKY_OF, bus.OF_CNT);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bus.IN_VALID = 1'b1;
    bus.Y = 6'd5;
    bus.SEL = 1'b0;
    bus.OF_SUM_REST = 1'b0;
    step();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.OUT_VALID !== 1'b1 || bus.R !== 6'd5 || bus.COUNT !== 3'd1) begin
      errors++;
      $display("FAIL basic_push: valid=%b r=%0d cnt=%0d want 1 5 1", bus.OUT_VALID, bus.R, bus.COUNT);
    end
    checks++;
    if (bus.FLAG_Z !== 1'b0 || bus.FLAG_N !== 1'b0 || bus.R_SEL !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: z=%b n=%b sel=%b want 0 0 0", bus.FLAG_Z, bus.FLAG_N, bus.R_SEL);
    end
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd0 || bus.R !== 6'd0 || bus.OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop: cnt=%0d r=%0d valid=%b want 0 0 0", bus.COUNT, bus.R, bus.OUT_VALID);
    end
  endtask

  task automatic test_flags();
    bus.IN_VALID = 1'b1;
    bus.Y = 6'b111101;
    bus.SEL = 1'b1;
    step();
    bus.Y = 6'd0;
    bus.SEL = 1'b0;
    step();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.R !== 6'b111101 || bus.FLAG_N !== 1'b1 || bus.FLAG_Z !== 1'b0) begin
      errors++;
      $display("FAIL flags_neg: r=%b n=%b z=%b want 111101 1 0", bus.R, bus.FLAG_N, bus.FLAG_Z);
    end
    checks++;
    if (bus.R_SEL !== 1'b1 || bus.COUNT !== 3'd2) begin
      errors++; $display("FAIL flags_sel: sel=%b cnt=%0d want 1 2", bus.R_SEL, bus.COUNT);
    end
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.R !== 6'd0 || bus.FLAG_Z !== 1'b1 || bus.FLAG_N !== 1'b0 || bus.OUT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL flags_zero: r=%0d z=%b n=%b valid=%b want 0 1 0 1", bus.R, bus.FLAG_Z, bus.FLAG_N, bus.OUT_VALID);
    end
    checks++;
    if (bus.R_SEL !== 1'b0 || bus.COUNT !== 3'd1) begin
      errors++; $display("FAIL flags_zero_sel: sel=%b cnt=%0d want 0 1", bus.R_SEL, bus.COUNT);
    end
    bus.OUT_READY = 1'b1;
    step();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd0 || bus.FLAG_Z !== 1'b0) begin
      errors++; $display("FAIL flags_drain: cnt=%0d z=%b want 0 0", bus.COUNT, bus.FLAG_Z);
    end
  endtask

  task automatic test_full();
    logic [5:0] exp;
    bus.IN_VALID = 1'b1;
    bus.SEL = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.Y = 6'(i);
      step();
    end
    bus.Y = 6'd5;
    checks++;
    if (bus.IN_READY !== 1'b0 || bus.COUNT !== 3'd4) begin
      errors++; $display("FAIL full_ready: rdy=%b cnt=%0d want 0 4", bus.IN_READY, bus.COUNT);
    end
    step();
    checks++;
    if (bus.COUNT !== 3'd4 || bus.R !== 6'd1) begin
      errors++; $display("FAIL full_ignore: cnt=%0d r=%0d want 4 1", bus.COUNT, bus.R);
    end
    bus.OUT_READY = 1'b1;
    #1;
    checks++;
    if (bus.IN_READY !== 1'b0) begin
      errors++; $display("FAIL full_no_pass: rdy=%b want 0", bus.IN_READY);
    end
    step();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.IN_READY !== 1'b1 || bus.COUNT !== 3'd3 || bus.R !== 6'd2) begin
      errors++;
      $display("FAIL full_after_pop: rdy=%b cnt=%0d r=%0d want 1 3 2", bus.IN_READY, bus.COUNT, bus.R);
    end
    step();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd4) begin
      errors++; $display("FAIL full_fifth: cnt=%0d want 4", bus.COUNT);
    end
    for (int i = 2; i <= 5; i++) begin
      exp = 6'(i);
      checks++;
      if (bus.R !== exp) begin
        errors++; $display("FAIL full_order: got %0d want %0d", bus.R, exp);
      end
      bus.OUT_READY = 1'b1;
      step();
    end
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd0 || bus.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL full_drain: cnt=%0d valid=%b want 0 0", bus.COUNT, bus.OUT_VALID);
    end
  endtask

  task automatic test_overflow();
    bus.IN_VALID = 1'b1;
    bus.OF_SUM_REST = 1'b1;
    bus.Y = 6'b100000;
    bus.SEL = 1'b0;
    step();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.STICKY_OF !== 1'b1 || bus.OF_CNT !== 4'd1) begin
      errors++; $display("FAIL of_set: sticky=%b cnt=%0d want 1 1", bus.STICKY_OF, bus.OF_CNT);
    end
    bus.IN_VALID = 1'b1;
    bus.CLR_OF = 1'b1;
    bus.Y = 6'b011111;
    bus.SEL = 1'b1;
    step();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.STICKY_OF !== 1'b1 || bus.OF_CNT !== 4'd1 || bus.COUNT !== 3'd2) begin
      errors++;
      $display("FAIL of_clr_set: sticky=%b cnt=%0d occ=%0d want 1 1 2", bus.STICKY_OF, bus.OF_CNT, bus.COUNT);
    end
    step();
    bus.CLR_OF = 1'b0;
    bus.OF_SUM_REST = 1'b0;
    checks++;
    if (bus.STICKY_OF !== 1'b0 || bus.OF_CNT !== 4'd0) begin
      errors++; $display("FAIL of_clr: sticky=%b cnt=%0d want 0 0", bus.STICKY_OF, bus.OF_CNT);
    end
    checks++;
    if (bus.R !== 6'b100000 || bus.FLAG_OF !== 1'b1 || bus.FLAG_N !== 1'b1) begin
      errors++;
      $display("FAIL of_head: r=%b of=%b n=%b want 100000 1 1", bus.R, bus.FLAG_OF, bus.FLAG_N);
    end
    bus.OUT_READY = 1'b1;
    step();
    checks++;
    if (bus.R !== 6'b011111 || bus.FLAG_OF !== 1'b1 || bus.FLAG_N !== 1'b0 || bus.R_SEL !== 1'b1) begin
      errors++;
      $display("FAIL of_head2: r=%b of=%b n=%b sel=%b want 011111 1 0 1", bus.R, bus.FLAG_OF, bus.FLAG_N, bus.R_SEL);
    end
    step();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd0 || bus.FLAG_OF !== 1'b0) begin
      errors++; $display("FAIL of_drain: cnt=%0d of=%b want 0 0", bus.COUNT, bus.FLAG_OF);
    end
  endtask

  task automatic test_saturate();
    logic [5:0] exp;
    bus.IN_VALID = 1'b1;
    bus.OF_SUM_REST = 1'b1;
    bus.SEL = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.Y = 6'(i);
      exp = 6'(i);
      step();
      checks++;
      if (bus.COUNT !== 3'd1 || bus.R !== exp) begin
        errors++; $display("FAIL sat_stream: cnt=%0d r=%0d want 1 %0d", bus.COUNT, bus.R, exp);
      end
    end
    bus.IN_VALID = 1'b0;
    bus.OF_SUM_REST = 1'b0;
    checks++;
    if (bus.OF_CNT !== 4'd15 || bus.STICKY_OF !== 1'b1) begin
      errors++; $display("FAIL sat_cnt: cnt=%0d sticky=%b want 15 1", bus.OF_CNT, bus.STICKY_OF);
    end
    step();
    bus.OUT_READY = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd0 || bus.OF_CNT !== 4'd15) begin
      errors++; $display("FAIL sat_hold: occ=%0d cnt=%0d want 0 15", bus.COUNT, bus.OF_CNT);
    end
  endtask

  task automatic test_async_reset();
    bus.IN_VALID = 1'b1;
    bus.OF_SUM_REST = 1'b0;
    for (int i = 10; i < 13; i++) begin
      bus.Y = 6'(i);
      step();
    end
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.COUNT !== 3'd3 || bus.R !== 6'd10) begin
      errors++; $display("FAIL ar_fill: cnt=%0d r=%0d want 3 10", bus.COUNT, bus.R);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.COUNT !== 3'd0 || bus.OUT_VALID !== 1'b0 || bus.R !== 6'd0) begin
      errors++;
      $display("FAIL ar_clear: cnt=%0d valid=%b r=%0d want 0 0 0", bus.COUNT, bus.OUT_VALID, bus.R);
    end
    checks++;
    if (bus.STICKY_OF !== 1'b0 || bus.OF_CNT !== 4'd0 || bus.IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL ar_status: sticky=%b cnt=%0d rdy=%b want 0 0 0", bus.STICKY_OF, bus.OF_CNT, bus.IN_READY);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.Y = 6'd7;
    step();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.R !== 6'd7 || bus.COUNT !== 3'd1 || bus.OUT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL ar_repush: r=%0d cnt=%0d valid=%b want 7 1 1", bus.R, bus.COUNT, bus.OUT_VALID);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_flags();
    test_full();
    test_overflow();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
